// File: rtl/polj_small_exe3_ctrl.sv
// rtl/polj_small_exe3_ctrl.sv - mode-3 small-poly sequencer: ram1 beat reads, delayed ram2 writes, f_ctr select
module polj_small_exe3_ctrl #(
    parameter int NTRU_N = 509,
    parameter int CPW    = 4,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    output logic          ram1_ena,
    output logic          ram1_enb,
    output logic [AW-1:0] ram1_addra,
    output logic [AW-1:0] ram1_addrb,
    output logic          ram2_wea,
    output logic          ram2_web,
    output logic [AW-1:0] ram2_addra,
    output logic [AW-1:0] ram2_addrb,
    output logic          f_ctr,
    output logic          busy,
    output logic          done
);

    localparam int BEATS = (NTRU_N + 2*CPW - 1) / (2*CPW);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   wr_cnt;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   dst_q;
    logic [RD_LAT-1:0] pipe_v;
    logic [CW-1:0]   pipe_k [RD_LAT];

    logic            rd_en;
    logic            wr_en;
    logic [CW-1:0]   wr_k;
    logic            start_acc;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   wr_addr;

    assign rd_en     = (state == S_RUN);
    assign wr_en     = pipe_v[RD_LAT-1];
    assign wr_k      = pipe_k[RD_LAT-1];
    assign start_acc = start && (state == S_IDLE);
    assign rd_addr   = src_q + AW'({rd_cnt, 1'b0});
    assign wr_addr   = dst_q + AW'({wr_k, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (rd_cnt == CW'(BEATS-1)) state_nxt = S_DRAIN;
            S_DRAIN: if (wr_en && (wr_cnt == CW'(BEATS-1))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Beat counters and the {valid, beat} shift that mirrors ram1 read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_k[i] <= '0;
            end
        end else begin
            if (start_acc) begin
                src_q  <= src_base;
                dst_q  <= dst_base;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + CW'(1);
                if (wr_en) wr_cnt <= wr_cnt + CW'(1);
            end
            pipe_v[0] <= rd_en;
            pipe_k[0] <= rd_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_k[i] <= pipe_k[i-1];
            end
        end
    end

    always_comb begin
        ram1_ena   = 1'b0;
        ram1_enb   = 1'b0;
        ram1_addra = '0;
        ram1_addrb = '0;
        ram2_wea   = 1'b0;
        ram2_web   = 1'b0;
        ram2_addra = '0;
        ram2_addrb = '0;
        f_ctr      = 1'b1;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        if (rd_en) begin
            ram1_ena   = 1'b1;
            ram1_enb   = 1'b1;
            ram1_addra = rd_addr;
            ram1_addrb = rd_addr + AW'(1);
        end
        // Only the write of beat 0 takes the -3*g0 path; every other cycle keeps carry mode
        if (wr_en) begin
            ram2_wea   = 1'b1;
            ram2_web   = 1'b1;
            ram2_addra = wr_addr;
            ram2_addrb = wr_addr + AW'(1);
            f_ctr      = (wr_k != '0);
        end
    end

endmodule

// File: tb/tb_polj_small_exe3_ctrl.sv
// tb/tb_polj_small_exe3_ctrl.sv - directed self-checking bench for polj_small_exe3_ctrl
module tb_polj_small_exe3_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    localparam int NB [3] = '{64, 1, 4};
    localparam int NL [3] = '{1, 1, 2};

    logic       start    [3];
    logic [7:0] src      [3];
    logic [7:0] dst      [3];
    logic       r1_ena   [3];
    logic       r1_enb   [3];
    logic [7:0] r1_addra [3];
    logic [7:0] r1_addrb [3];
    logic       r2_wea   [3];
    logic       r2_web   [3];
    logic [7:0] r2_addra [3];
    logic [7:0] r2_addrb [3];
    logic       f_ctr    [3];
    logic       busy     [3];
    logic       done     [3];
    wire [39:0] obs      [3];

    int errors = 0;
    int checks = 0;

    polj_small_exe3_ctrl #(.NTRU_N(509), .RD_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .src_base(src[0]), .dst_base(dst[0]),
        .ram1_ena(r1_ena[0]), .ram1_enb(r1_enb[0]), .ram1_addra(r1_addra[0]), .ram1_addrb(r1_addrb[0]),
        .ram2_wea(r2_wea[0]), .ram2_web(r2_web[0]), .ram2_addra(r2_addra[0]), .ram2_addrb(r2_addrb[0]),
        .f_ctr(f_ctr[0]), .busy(busy[0]), .done(done[0]));

    polj_small_exe3_ctrl #(.NTRU_N(8), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .src_base(src[1]), .dst_base(dst[1]),
        .ram1_ena(r1_ena[1]), .ram1_enb(r1_enb[1]), .ram1_addra(r1_addra[1]), .ram1_addrb(r1_addrb[1]),
        .ram2_wea(r2_wea[1]), .ram2_web(r2_web[1]), .ram2_addra(r2_addra[1]), .ram2_addrb(r2_addrb[1]),
        .f_ctr(f_ctr[1]), .busy(busy[1]), .done(done[1]));

    polj_small_exe3_ctrl #(.NTRU_N(32), .RD_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .src_base(src[2]), .dst_base(dst[2]),
        .ram1_ena(r1_ena[2]), .ram1_enb(r1_enb[2]), .ram1_addra(r1_addra[2]), .ram1_addrb(r1_addrb[2]),
        .ram2_wea(r2_wea[2]), .ram2_web(r2_web[2]), .ram2_addra(r2_addra[2]), .ram2_addrb(r2_addrb[2]),
        .f_ctr(f_ctr[2]), .busy(busy[2]), .done(done[2]));

    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign obs[g] = {r1_ena[g], r1_enb[g], r1_addra[g], r1_addrb[g],
                         r2_wea[g], r2_web[g], r2_addra[g], r2_addrb[g],
                         f_ctr[g], busy[g], done[g]};
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycle c counts from the cycle in which start was high (c=0)
    function automatic logic [39:0] exp_vec(input int beats, input int lat,
                                            input logic [7:0] s, input logic [7:0] d, input int c);
        logic       rd, wr, f, bz, dn;
        logic [7:0] a1a, a1b, a2a, a2b;
        rd  = (c >= 1) && (c <= beats);
        wr  = (c >= 1 + lat) && (c <= beats + lat);
        a1a = rd ? s + 8'(2*(c-1)) : 8'h00;
        a1b = rd ? a1a + 8'd1 : 8'h00;
        a2a = wr ? d + 8'(2*(c-1-lat)) : 8'h00;
        a2b = wr ? a2a + 8'd1 : 8'h00;
        f   = !(c == 1 + lat);
        bz  = (c >= 1) && (c <= beats + lat + 1);
        dn  = (c == beats + lat + 1);
        return {rd, rd, a1a, a1b, wr, wr, a2a, a2b, f, bz, dn};
    endfunction

    task automatic run(input int i, input logic [7:0] s, input logic [7:0] d,
                       input bit pulse, input string tag);
        int nb;
        int lt;
        nb = NB[i];
        lt = NL[i];
        src[i]   = s;
        dst[i]   = d;
        start[i] = 1'b1;
        for (int c = 1; c <= nb + lt + 2; c++) begin
            @(posedge clk);
            #1;
            start[i] = 1'b0;
            if (pulse && (c == 5 || c == nb + 2)) begin
                start[i] = 1'b1;
                src[i]   = 8'h55;
                dst[i]   = 8'h33;
            end
            @(negedge clk);
            chk($sformatf("%s c%0d", tag, c), obs[i], exp_vec(nb, lt, s, d, c));
        end
        start[i] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            src[i]   = 8'h00;
            dst[i]   = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("reset u%0d", i), obs[i], exp_vec(NB[i], NL[i], 0, 0, 0));
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 8'h00, 8'h80, 1'b0, "t1");
        run(0, 8'h20, 8'hA0, 1'b1, "t3_pulse");
        run(0, 8'h20, 8'hA0, 1'b0, "t4_b2b");
        run(1, 8'h40, 8'h60, 1'b0, "t2_one_beat");
        run(2, 8'hFE, 8'hFC, 1'b0, "t6_wrap_lat2");

        src[0]   = 8'h00;
        dst[0]   = 8'h80;
        start[0] = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk);
            #1;
            start[0] = 1'b0;
            @(negedge clk);
            chk($sformatf("t5_pre c%0d", c), obs[0], exp_vec(64, 1, 8'h00, 8'h80, c));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async", obs[0], exp_vec(64, 1, 0, 0, 0));
        repeat (2) begin
            @(negedge clk);
            chk("t5_held", obs[0], exp_vec(64, 1, 0, 0, 0));
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_after", obs[0], exp_vec(64, 1, 0, 0, 0));
        end
        run(0, 8'h00, 8'h80, 1'b0, "t5_rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
